bridge_ctrl: RTL

BRIDGE_CTRL -- requirements
Module: bridge_ctrl

---
 rtl/bridge_ctrl_if.sv | 34 +++
 rtl/bridge_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/bridge_ctrl_if.sv
// CPU-side MEM-stage bus of the data bridge.
// Master is the pipeline, slave is bridge_ctrl.
interface bridge_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic [1:0]  cpu_rsel;
  logic        addr_err;

  modport master (
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_stall,
    input  cpu_rdata,
    input  cpu_rsel,
    input  addr_err
  );

  modport slave (
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_stall,
    output cpu_rdata,
    output cpu_rsel,
    output addr_err
  );
endinterface

// File: rtl/bridge_ctrl.sv
// Data-side bridge: routes MEM-stage accesses to data memory
// or one of two 3-word devices; device loads stall two cycles.
module bridge_ctrl #(
  parameter logic [31:0] DM_TOP    = 32'h0000_2fff,
  parameter logic [31:0] DEV0_BASE = 32'h0000_7f00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7f10
) (
  input  logic        clk,
  input  logic        reset,
  bridge_ctrl_if.slave cpu,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  input  logic [31:0] dm_rdata,
  output logic        dev0_we,
  output logic        dev1_we,
  output logic [1:0]  dev_addr,
  output logic [31:0] dev_wdata,
  input  logic [31:0] dev0_rdata,
  input  logic [31:0] dev1_rdata,
  input  logic        dev0_irq,
  input  logic        dev1_irq,
  output logic [5:0]  hw_int
);

  localparam logic [31:0] DEV0_LAST = DEV0_BASE + 32'd11;
  localparam logic [31:0] DEV1_LAST = DEV1_BASE + 32'd11;

  typedef enum logic [1:0] {
    IDLE,
    DEV_RD,
    DONE
  } state_t;

  state_t      state;
  logic        sel_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;

  logic dm_hit;
  logic dev0_hit;
  logic dev1_hit;
  logic dev_hit;
  logic aligned;
  logic idle;
  logic go;
  logic rd_go;

  assign aligned  = cpu.cpu_addr[1:0] == 2'b00;
  assign dm_hit   = cpu.cpu_addr <= DM_TOP;
  assign dev0_hit = (cpu.cpu_addr >= DEV0_BASE) &&
                    (cpu.cpu_addr <= DEV0_LAST);
  assign dev1_hit = (cpu.cpu_addr >= DEV1_BASE) &&
                    (cpu.cpu_addr <= DEV1_LAST);
  assign dev_hit  = dev0_hit | dev1_hit;

  // Reset gates every strobe, stall and return path.
  assign idle  = reset && (state == IDLE);
  assign go    = idle && cpu.cpu_req && aligned;
  assign rd_go = go && !cpu.cpu_we && dev_hit;

  assign cpu.addr_err = idle && cpu.cpu_req &&
                        (!(dm_hit || dev_hit) || !aligned);

  assign dm_we   = go && cpu.cpu_we && dm_hit;
  assign dev0_we = go && cpu.cpu_we && dev0_hit;
  assign dev1_we = go && cpu.cpu_we && dev1_hit;

  assign dm_addr   = cpu.cpu_addr;
  assign dev_wdata = cpu.cpu_wdata;
  assign dev_addr  = (state == DEV_RD) ? off_q
                                       : cpu.cpu_addr[3:2];

  assign cpu.cpu_stall = rd_go || (reset && state == DEV_RD);

  always_comb begin
    cpu.cpu_rsel  = 2'b00;
    cpu.cpu_rdata = 32'h0;
    if (go && !cpu.cpu_we && dm_hit) begin
      cpu.cpu_rsel  = 2'b01;
      cpu.cpu_rdata = dm_rdata;
    end else if (reset && state == DONE) begin
      cpu.cpu_rsel  = 2'b10;
      cpu.cpu_rdata = rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      sel_q   <= 1'b0;
      off_q   <= 2'b00;
      rdata_q <= 32'h0;
      hw_int  <= 6'h0;
    end else begin
      hw_int <= {4'b0000, dev1_irq, dev0_irq};
      unique case (state)
        IDLE: begin
          if (rd_go) begin
            state <= DEV_RD;
            sel_q <= dev1_hit;
            off_q <= cpu.cpu_addr[3:2];
          end
        end
        DEV_RD: begin
          rdata_q <= sel_q ? dev1_rdata : dev0_rdata;
          state   <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
